cflog_drain: RTL and testbench

- Read-side counterpart of the Control-Flow Log memory: on a flush request it reads every logged 16-bit word out through a dedicated synchronous read port and streams it to the attestation transmitter over a valid/ready word stream.
- Frames the dump as magic header, word count, payload, and XOR checksum.
- While draining, it stalls the CFA and Spec-CFA writers.
- On completion, it pulses a clear so that the log pointer restarts at zero.

---
 rtl/cflog_drain.sv | 161 ++++++++++++++++
 tb/tb_cflog_drain.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cflog_drain.sv
// cflog_drain: reads the Control-Flow Log out through a synchronous read port
// and streams it as a framed dump (magic, count, payload, XOR checksum).
module cflog_drain #(
   parameter logic [15:0] CFLOW_LOGS_SIZE = 16'h0100,
   parameter int          ADDR_MSB        = 8,
   parameter logic [15:0] HDR_MAGIC       = 16'hCF10
) (
   input  logic                mclk,
   input  logic                puc_rst,
   input  logic                flush_req,
   input  logic [15:0]         cflow_logs_ptr,
   output logic                rd_en,
   output logic [ADDR_MSB:0]   rd_addr,
   input  logic [15:0]         rd_data,
   output logic [15:0]         tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                hold_cfa,
   output logic                busy,
   output logic                flush_done,
   output logic                log_clear,
   output logic [2:0]          dbg_state
);

   // Stream handshake: a word moves on each rising mclk where tx_valid and
   // tx_ready are both high; once raised, tx_valid and tx_data hold until then.

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_CNT  = 3'd2,
      S_RD   = 3'd3,
      S_CAP  = 3'd4,
      S_SEND = 3'd5,
      S_CSUM = 3'd6,
      S_DONE = 3'd7
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [15:0]       cnt;
   logic [15:0]       idx;
   logic [15:0]       csum;
   logic [15:0]       word_buf;
   logic [ADDR_MSB:0] rd_addr_q;
   logic              accept;
   logic [15:0]       ptr_clamped;

   assign accept      = tx_valid & tx_ready;
   assign ptr_clamped = (cflow_logs_ptr > CFLOW_LOGS_SIZE) ? CFLOW_LOGS_SIZE : cflow_logs_ptr;

   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (flush_req) state_nxt = S_HDR;
         S_HDR:  if (accept) state_nxt = S_CNT;
         S_CNT:  if (accept) state_nxt = (cnt == 16'd0) ? S_CSUM : S_RD;
         S_RD:   state_nxt = S_CAP;
         S_CAP:  state_nxt = S_SEND;
         S_SEND: if (accept) state_nxt = ((idx + 16'd1) == cnt) ? S_CSUM : S_RD;
         S_CSUM: if (accept) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // The checksum is seeded with the count word; the magic word never enters it.
   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         cnt       <= '0;
         idx       <= '0;
         csum      <= '0;
         word_buf  <= '0;
         rd_addr_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (flush_req) begin
                  cnt  <= ptr_clamped;
                  idx  <= '0;
                  csum <= '0;
               end
            end
            S_CNT: begin
               if (accept) csum <= cnt;
            end
            S_RD: begin
               rd_addr_q <= idx[ADDR_MSB:0];
            end
            S_CAP: begin
               word_buf <= rd_data;
            end
            S_SEND: begin
               if (accept) begin
                  csum <= csum ^ word_buf;
                  idx  <= idx + 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      tx_data    = '0;
      tx_valid   = 1'b0;
      rd_en      = 1'b0;
      rd_addr    = rd_addr_q;
      flush_done = 1'b0;
      log_clear  = 1'b0;
      busy       = (state != S_IDLE);
      hold_cfa   = (state != S_IDLE);
      dbg_state  = state;
      case (state)
         S_HDR: begin
            tx_data  = HDR_MAGIC;
            tx_valid = 1'b1;
         end
         S_CNT: begin
            tx_data  = cnt;
            tx_valid = 1'b1;
         end
         S_RD: begin
            rd_en   = 1'b1;
            rd_addr = idx[ADDR_MSB:0];
         end
         S_SEND: begin
            tx_data  = word_buf;
            tx_valid = 1'b1;
         end
         S_CSUM: begin
            tx_data  = csum;
            tx_valid = 1'b1;
         end
         S_DONE: begin
            flush_done = 1'b1;
            log_clear  = 1'b1;
         end
         default: begin
         end
      endcase
   end

   a_tx_hold: assert property (@(posedge mclk) disable iff (puc_rst)
      (tx_valid && !tx_ready) |=> (tx_valid && $stable(tx_data)));

   a_rd_range: assert property (@(posedge mclk) disable iff (puc_rst)
      rd_en |-> (16'(rd_addr) < CFLOW_LOGS_SIZE) && (16'(rd_addr) < cnt));

   a_done_clear: assert property (@(posedge mclk) flush_done == log_clear);

endmodule

// File: tb/tb_cflog_drain.sv
// Self-checking bench for cflog_drain: table vectors, corner sequences and
// randomized dumps checked against a frame-level reference model.
module tb_cflog_drain;

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic        flush_req;
   logic [15:0] cflow_logs_ptr;
   logic        rd_en;
   logic [8:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        hold_cfa;
   logic        busy;
   logic        flush_done;
   logic        log_clear;
   logic [2:0]  dbg_state;

   always #5 mclk = ~mclk;

   cflog_drain dut (
      .mclk           (mclk),
      .puc_rst        (puc_rst),
      .flush_req      (flush_req),
      .cflow_logs_ptr (cflow_logs_ptr),
      .rd_en          (rd_en),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .hold_cfa       (hold_cfa),
      .busy           (busy),
      .flush_done     (flush_done),
      .log_clear      (log_clear),
      .dbg_state      (dbg_state)
   );

   // log memory with one-cycle synchronous read
   logic [15:0] log_mem [0:255];
   always @(posedge mclk) begin
      if (rd_en) rd_data <= log_mem[rd_addr[7:0]];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   // ready driver: mode 0 always ready, 1 toggling, 2 random; stall_left forces low
   int ready_mode = 0;
   int stall_left = 0;
   logic ready_tog = 1'b1;
   always begin
      @(posedge mclk);
      #1;
      if (stall_left > 0) begin
         tx_ready = 1'b0;
         stall_left--;
      end else begin
         case (ready_mode)
            1: begin ready_tog = ~ready_tog; tx_ready = ready_tog; end
            2: tx_ready = ($urandom_range(0, 1) == 1);
            default: tx_ready = 1'b1;
         endcase
      end
   end

   // scoreboard and monitor
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   int m_cnt;
   int rd_exp, rd_cnt, rd_errs, stall_errs, hold_errs, hold_cyc, done_cnt, clr_cnt;
   logic [8:0]  last_addr;
   logic        prev_stall = 1'b0;
   logic        prev_rst   = 1'b1;
   logic [15:0] prev_data  = '0;
   logic [8:0]  prev_addr  = '0;

   always @(negedge mclk) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (prev_stall && !prev_rst && (!tx_valid || tx_data !== prev_data)) stall_errs++;
      if (rd_en) begin
         if (rd_addr !== rd_exp[8:0]) rd_errs++;
         rd_exp++;
         rd_cnt++;
         last_addr = rd_addr;
      end else if (!prev_rst && rd_addr !== prev_addr) begin
         rd_errs++;
      end
      if (hold_cfa !== busy) hold_errs++;
      if (flush_done !== log_clear) hold_errs++;
      if (hold_cfa) hold_cyc++;
      if (flush_done) done_cnt++;
      if (log_clear) clr_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_rst   = puc_rst;
      prev_addr  = rd_addr;
   end

   task automatic clear_mon();
      got_q.delete();
      rd_exp = 0; rd_cnt = 0; rd_errs = 0; stall_errs = 0;
      hold_errs = 0; hold_cyc = 0; done_cnt = 0; clr_cnt = 0;
   endtask

   // fill kinds: 0 basic trace words, 1 word i = i, 2 random
   task automatic fill_mem(input int kind);
      for (int i = 0; i < 256; i++) begin
         case (kind)
            1: log_mem[i] = 16'(i);
            default: log_mem[i] = 16'($urandom);
         endcase
      end
      if (kind == 0) begin
         log_mem[0] = 16'hE000; log_mem[1] = 16'hE010;
         log_mem[2] = 16'hE020; log_mem[3] = 16'hE0A4;
      end
   endtask

   // reference model: whole expected frame from the pointer and log contents
   task automatic build_exp(input logic [15:0] ptr);
      logic [15:0] c;
      m_cnt = (ptr > 16'h0100) ? 256 : int'(ptr);
      exp_q.delete();
      exp_q.push_back(16'hCF10);
      exp_q.push_back(16'(m_cnt));
      c = 16'(m_cnt);
      for (int i = 0; i < m_cnt; i++) begin
         exp_q.push_back(log_mem[i]);
         c = c ^ log_mem[i];
      end
      exp_q.push_back(c);
   endtask

   task automatic pulse_flush();
      flush_req = 1'b1;
      @(posedge mclk); #1;
      flush_req = 1'b0;
   endtask

   task automatic run_wait(input int bound, input bit stall_mid, input bit req_in_send,
                           input bit req_in_done);
      bit stalled = 0;
      bit sent = 0;
      bit ok = 0;
      for (int i = 0; i < bound; i++) begin
         if (flush_done) begin ok = 1; break; end
         if (stall_mid && !stalled && got_q.size() >= 4) begin stall_left = 5; stalled = 1; end
         if (req_in_send && !sent && got_q.size() >= 2 && tx_valid) begin
            flush_req = 1'b1; sent = 1;
         end else begin
            flush_req = 1'b0;
         end
         @(posedge mclk); #1;
      end
      flush_req = 1'b0;
      check("flush_done seen within bound", 32'(ok), 1);
      if (ok && req_in_done) flush_req = 1'b1;
      @(posedge mclk); #1;
      flush_req = 1'b0;
      repeat (8) @(posedge mclk);
      #1;
   endtask

   task automatic check_frame(input string name, input int hold_exp);
      check({name, " word count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s word %0d: got %h, required %h", name, i, got_q[i], exp_q[i]);
            break;
         end
      end
      check({name, " flush_done pulses"}, done_cnt, 1);
      check({name, " log_clear pulses"}, clr_cnt, 1);
      check({name, " rd_en cycles"}, rd_cnt, m_cnt);
      check({name, " rd_addr order/hold errors"}, rd_errs, 0);
      check({name, " stall stability errors"}, stall_errs, 0);
      check({name, " hold/busy/pulse errors"}, hold_errs, 0);
      if (m_cnt > 0) check({name, " last rd_addr"}, last_addr, 32'(m_cnt - 1));
      if (hold_exp >= 0) check({name, " hold_cfa cycles"}, hold_cyc, hold_exp);
      check({name, " idle after dump"}, {busy, hold_cfa, tx_valid}, 0);
   endtask

   typedef struct {
      string       name;
      logic [15:0] ptr;
      int          fill;
      int          mode;
      bit          stall_mid;
      logic [15:0] exp_cnt;
      logic [15:0] exp_csum;
   } vec_t;

   vec_t vecs[8];

   initial begin
      puc_rst = 1'b1; flush_req = 1'b0; cflow_logs_ptr = '0; tx_ready = 1'b1;
      clear_mon();
      repeat (3) @(posedge mclk);
      #1;
      check("reset outputs", {tx_valid, tx_data, rd_en, rd_addr, hold_cfa, busy, flush_done, log_clear},
            0);
      puc_rst = 1'b0;
      @(posedge mclk); #1;
      check("reset state idle", dbg_state, 0);

      vecs[0] = '{"basic",      16'd4,      0, 0, 1'b0, 16'h0004, 16'h0090};
      vecs[1] = '{"empty",      16'd0,      1, 0, 1'b0, 16'h0000, 16'h0000};
      vecs[2] = '{"backpress",  16'd4,      0, 1, 1'b1, 16'h0004, 16'h0090};
      vecs[3] = '{"overflow",   16'h0180,   1, 0, 1'b0, 16'h0100, 16'h0100};
      vecs[4] = '{"exact_full", 16'h0100,   1, 0, 1'b0, 16'h0100, 16'h0100};
      vecs[5] = '{"one_word",   16'd1,      1, 0, 1'b0, 16'h0001, 16'h0001};
      vecs[6] = '{"ptr_max",    16'hFFFF,   1, 2, 1'b0, 16'h0100, 16'h0100};
      vecs[7] = '{"three",      16'd3,      1, 0, 1'b0, 16'h0003, 16'h0000};

      foreach (vecs[v]) begin
         fill_mem(vecs[v].fill);
         cflow_logs_ptr = vecs[v].ptr;
         ready_mode = vecs[v].mode;
         build_exp(vecs[v].ptr);
         clear_mon();
         pulse_flush();
         run_wait(5000, vecs[v].stall_mid, 1'b0, 1'b0);
         if (got_q.size() >= 3) begin
            check({vecs[v].name, " count word"}, got_q[1], vecs[v].exp_cnt);
            check({vecs[v].name, " checksum word"}, got_q[got_q.size() - 1], vecs[v].exp_csum);
         end else begin
            check({vecs[v].name, " frame length"}, got_q.size(), 3);
         end
         check_frame(vecs[v].name, (vecs[v].mode == 0) ? 4 + 3 * int'(vecs[v].exp_cnt) : -1);
      end

      // reset after the second payload word is accepted aborts the dump
      ready_mode = 0;
      fill_mem(0);
      cflow_logs_ptr = 16'd4;
      build_exp(16'd4);
      clear_mon();
      pulse_flush();
      for (int i = 0; i < 100; i++) begin
         if (got_q.size() >= 4) break;
         @(posedge mclk); #1;
      end
      check("abort reached 2nd payload", got_q.size(), 4);
      puc_rst = 1'b1;
      @(posedge mclk); #1;
      puc_rst = 1'b0;
      check("abort outputs zero",
            {tx_valid, tx_data, rd_en, rd_addr, hold_cfa, busy, flush_done, log_clear}, 0);
      check("abort state idle", dbg_state, 0);
      repeat (10) @(posedge mclk);
      #1;
      check("abort no flush_done", done_cnt, 0);
      check("abort no log_clear", clr_cnt, 0);
      clear_mon();
      pulse_flush();
      run_wait(500, 1'b0, 1'b0, 1'b0);
      check_frame("after_abort", 16);

      // flush requests during SEND and in DONE are dropped
      clear_mon();
      pulse_flush();
      run_wait(500, 1'b0, 1'b1, 1'b1);
      check_frame("rereq", 16);

      // flush_req together with reset: reset wins
      clear_mon();
      puc_rst = 1'b1; flush_req = 1'b1;
      @(posedge mclk); #1;
      puc_rst = 1'b0; flush_req = 1'b0;
      repeat (3) @(posedge mclk);
      #1;
      check("req with reset ignored", {busy, hold_cfa}, 0);

      // randomized dumps against the reference model
      for (int r = 0; r < 10; r++) begin
         fill_mem(2);
         cflow_logs_ptr = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2))
                                                      : 16'($urandom_range(0, 300));
         ready_mode = 2;
         build_exp(cflow_logs_ptr);
         clear_mon();
         pulse_flush();
         run_wait(8000, 1'b0, 1'b0, 1'b0);
         check_frame("random", -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
